// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line engine.
// Holds the response encoding, FSM states, CRC7 polynomial and frame sizes.
package sd_pkg;

   typedef enum logic [1:0] {
      RT_NONE      = 2'd0,
      RT_R48       = 2'd1,
      RT_R48_NOCRC = 2'd2,
      RT_R136      = 2'd3
   } resp_type_e;

   typedef enum logic [2:0] {
      IDLE,
      TX,
      WAIT_START,
      RX,
      GAP
   } state_e;

   // x^7 + x^3 + 1, x^7 term implicit
   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int CMD_LEN  = 48;
   localparam int R48_LEN  = 48;
   localparam int R136_LEN = 136;

   function automatic logic [6:0] crc7_step(
      input logic [6:0] crc,
      input logic       b
   );
      logic fb;
      fb = crc[6] ^ b;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator shared by the command and response paths.
// clear restarts from zero; with enable also set, the bit goes into the fresh CRC.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] base;

   assign base = clear ? 7'h00 : crc;

   always_ff @(posedge clk) begin
      if (rst)
         crc <= 7'h00;
      else if (enable)
         crc <= crc7_step(base, bit_in);
      else
         crc <= base;
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command, collects the R48/R136
// reply, checks CRC7 and end bit, then enforces the NCC idle gap.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int RESP_TIMEOUT = 64,
   parameter int NCC          = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [5:0]   cmd_idx,
   input  logic [31:0]  arg,
   input  logic [1:0]   resp_type,
   output logic         cmd_out,
   output logic         cmd_oe,
   input  logic         cmd_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] resp,
   output logic [5:0]   resp_idx,
   output logic         err_timeout,
   output logic         err_crc,
   output logic         err_end
);

   localparam int TXW = $clog2(CMD_LEN);
   localparam int RXW = $clog2(R136_LEN);
   localparam int TOW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam int GW  = (NCC > 1) ? $clog2(NCC) : 1;

   localparam logic [TXW-1:0] TX_DATA_END = TXW'(CMD_LEN - 10);
   localparam logic [TXW-1:0] TX_CRC_AT   = TXW'(CMD_LEN - 9);
   localparam logic [TXW-1:0] TX_LAST     = TXW'(CMD_LEN - 1);
   localparam logic [TOW-1:0] TO_LAST     = TOW'(RESP_TIMEOUT - 1);
   localparam logic [GW-1:0]  GAP_LAST    = GW'(NCC - 1);
   localparam logic [RXW-1:0] RX_R48_TOP  = RXW'(R48_LEN - 2);
   localparam logic [RXW-1:0] RX_R136_TOP = RXW'(R136_LEN - 2);
   localparam logic [RXW-1:0] RX_CRC_LO   = RXW'(8);
   localparam logic [RXW-1:0] RX_CRC_HI   = RXW'(127);

   state_e        state;
   resp_type_e    rt;
   logic [38:0]   tx_sr;
   logic [TXW-1:0] tx_cnt;
   logic [TOW-1:0] to_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [RXW-1:0] rx_idx;
   logic [126:0]  rx_sr;

   logic          crc_clr;
   logic          crc_en;
   logic          crc_bit;
   logic [6:0]    crc;

   sd_crc7 u_crc (
      .clk    (clk),
      .rst    (rst),
      .clear  (crc_clr),
      .enable (crc_en),
      .bit_in (crc_bit),
      .crc    (crc)
   );

   // Leading start bit is 0, so skipping it leaves a zero-init CRC unchanged.
   always_comb begin
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      crc_bit = 1'b0;
      case (state)
         IDLE: begin
            crc_clr = start;
         end
         TX: begin
            crc_en  = (tx_cnt <= TX_DATA_END);
            crc_bit = tx_sr[38];
         end
         WAIT_START: begin
            crc_clr = ~cmd_in;
         end
         RX: begin
            crc_en  = (rx_idx >= RX_CRC_LO) && (rx_idx <= RX_CRC_HI);
            crc_bit = cmd_in;
         end
         default: begin
            crc_clr = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rt          <= RT_NONE;
         tx_sr       <= '0;
         tx_cnt      <= '0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
         rx_idx      <= '0;
         rx_sr       <= '0;
         cmd_out     <= 1'b1;
         cmd_oe      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         resp        <= '0;
         resp_idx    <= '0;
         err_timeout <= 1'b0;
         err_crc     <= 1'b0;
         err_end     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rt          <= resp_type_e'(resp_type);
                  tx_sr       <= {1'b1, cmd_idx, arg};
                  tx_cnt      <= '0;
                  cmd_out     <= 1'b0;
                  cmd_oe      <= 1'b1;
                  busy        <= 1'b1;
                  resp        <= '0;
                  resp_idx    <= '0;
                  err_timeout <= 1'b0;
                  err_crc     <= 1'b0;
                  err_end     <= 1'b0;
                  state       <= TX;
               end
            end
            TX: begin
               if (tx_cnt == TX_LAST) begin
                  cmd_oe  <= 1'b0;
                  cmd_out <= 1'b1;
                  if (rt == RT_NONE) begin
                     done    <= 1'b1;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     to_cnt <= '0;
                     state  <= WAIT_START;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
                  // CRC is complete here; splice it plus the end bit in
                  if (tx_cnt == TX_CRC_AT) begin
                     cmd_out       <= crc[6];
                     tx_sr[38:32]  <= {crc[5:0], 1'b1};
                  end else begin
                     cmd_out <= tx_sr[38];
                     tx_sr   <= {tx_sr[37:0], 1'b0};
                  end
               end
            end
            WAIT_START: begin
               if (!cmd_in) begin
                  rx_sr  <= '0;
                  rx_idx <= (rt == RT_R136) ? RX_R136_TOP : RX_R48_TOP;
                  state  <= RX;
               end else if (to_cnt == TO_LAST) begin
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            RX: begin
               rx_sr <= {rx_sr[125:0], cmd_in};
               if (rx_idx == '0) begin
                  // rx_sr[k] holds frame bit k+1; cmd_in is the end bit
                  err_end <= ~cmd_in;
                  done    <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
                  if (rt == RT_R136) begin
                     resp     <= {rx_sr[126:0], cmd_in};
                     resp_idx <= '0;
                     err_crc  <= (crc != rx_sr[6:0]);
                  end else begin
                     resp     <= {96'd0, rx_sr[38:7]};
                     resp_idx <= rx_sr[44:39];
                     err_crc  <= (rt == RT_R48) && (crc != rx_sr[6:0]);
                  end
               end else begin
                  rx_idx <= rx_idx - 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: directed commands push expectations,
// a negedge monitor captures the CMD frame and checks each done pulse.
module tb_sd_cmd_engine;

   localparam int RT = 64;
   localparam int NC = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [5:0]   cmd_idx;
   logic [31:0]  arg_v;
   logic [1:0]   resp_type;
   logic         cmd_out;
   logic         cmd_oe;
   logic         cmd_in;
   logic         busy;
   logic         done;
   logic [127:0] resp;
   logic [5:0]   resp_idx;
   logic         err_timeout;
   logic         err_crc;
   logic         err_end;

   sd_cmd_engine #(.RESP_TIMEOUT(RT), .NCC(NC)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cmd_idx     (cmd_idx),
      .arg         (arg_v),
      .resp_type   (resp_type),
      .cmd_out     (cmd_out),
      .cmd_oe      (cmd_oe),
      .cmd_in      (cmd_in),
      .busy        (busy),
      .done        (done),
      .resp        (resp),
      .resp_idx    (resp_idx),
      .err_timeout (err_timeout),
      .err_crc     (err_crc),
      .err_end     (err_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [47:0]  tx;
      logic [127:0] rsp;
      logic [5:0]   idx;
      logic         to;
      logic         ce;
      logic         ee;
      int           dcyc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          last_done = 0;
   logic [47:0] tx_cap = '0;
   int          tx_n = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, ex, cyc);
      end
   endtask

   function automatic logic [6:0] crc7_f(input logic [127:0] v, input int n);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[6] ^ v[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   always @(negedge clk) begin
      if (rst || !busy) begin
         tx_n   = 0;
         tx_cap = '0;
      end else begin
         if (cmd_oe) begin
            tx_cap = {tx_cap[46:0], cmd_out};
            tx_n++;
         end
         if (done) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done at cyc %0d want none", cyc);
            end else begin
               mon_e = q.pop_front();
               chk("tx_frame", 128'(tx_cap), 128'(mon_e.tx));
               chk("tx_bits", 128'(tx_n), 128'd48);
               chk("done_cyc", 128'(cyc), 128'(mon_e.dcyc));
               chk("resp", resp, mon_e.rsp);
               chk("resp_idx", 128'(resp_idx), 128'(mon_e.idx));
               chk("err_timeout", 128'(err_timeout), 128'(mon_e.to));
               chk("err_crc", 128'(err_crc), 128'(mon_e.ce));
               chk("err_end", 128'(err_end), 128'(mon_e.ee));
            end
            last_done = cyc;
            tx_n      = 0;
            tx_cap    = '0;
         end
      end
   end

   // Caller sits on a negedge; start is sampled at the following posedge.
   task automatic send(input logic [5:0] idx, input logic [31:0] a,
                       input logic [1:0] rt, output int acc);
      cmd_idx   = idx;
      arg_v     = a;
      resp_type = rt;
      start     = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("busy_on_accept", 128'(busy), 128'd1);
   endtask

   task automatic reply(input int acc, input logic [135:0] fr,
                        input int len, input int d);
      while (cyc < acc + 47 + d) @(negedge clk);
      for (int i = len - 1; i >= 0; i--) begin
         cmd_in = fr[i];
         @(negedge clk);
      end
      cmd_in = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_wait: got busy=1 after %0d cycles want 0", n);
      end else begin
         chk("gap_len", 128'(cyc), 128'(last_done + NC));
      end
   endtask

   task automatic run(input logic [5:0] idx, input logic [31:0] a,
                      input logic [1:0] rt, input logic [47:0] txf,
                      input logic [135:0] fr, input int len, input int d,
                      input logic [127:0] rsp, input logic [5:0] ridx,
                      input logic to, input logic ce, input logic ee,
                      input logic poke);
      int   acc;
      exp_t e;
      send(idx, a, rt, acc);
      e.tx  = txf;
      e.rsp = rsp;
      e.idx = ridx;
      e.to  = to;
      e.ce  = ce;
      e.ee  = ee;
      if (rt == 2'd0)
         e.dcyc = acc + 48;
      else if (to)
         e.dcyc = acc + 48 + RT;
      else
         e.dcyc = acc + 48 + d + len - 1;
      q.push_back(e);
      if (poke) begin
         @(negedge clk);
         cmd_idx   = 6'd9;
         arg_v     = 32'hFFFF_FFFF;
         resp_type = 2'd0;
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (rt != 2'd0 && !to) reply(acc, fr, len, d);
      wait_idle();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   logic [119:0] cid;
   logic [135:0] fr136;
   logic [47:0]  tx_cmd2;
   logic [135:0] r8_ok;
   logic [135:0] r8_flip;
   logic [135:0] r8_end0;
   int           acc_r;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      cmd_idx   = '0;
      arg_v     = '0;
      resp_type = '0;
      cmd_in    = 1'b1;

      cid     = 120'h0353_4453_4433_3247_8012_3456_7800_C5;
      fr136   = {2'b00, 6'h3F, cid, crc7_f({8'h00, cid}, 120), 1'b1};
      tx_cmd2 = {2'b01, 6'd2, 32'h0,
                 crc7_f({88'h0, 2'b01, 6'd2, 32'h0}, 40), 1'b1};
      r8_ok   = {88'h0, 48'h08_0000_01AA_13};
      r8_flip = {88'h0, 48'h08_0000_01AB_13};
      r8_end0 = {88'h0, 48'h08_0000_01AA_12};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_oe", 128'(cmd_oe), 128'd0);
      chk("rst_cmd_out", 128'(cmd_out), 128'd1);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_resp", resp, 128'd0);
      chk("rst_resp_idx", 128'(resp_idx), 128'd0);
      chk("rst_errs", 128'({err_timeout, err_crc, err_end}), 128'd0);

      // CMD0, no response
      run(6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, '0, 48, 0,
          128'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // CMD8 R7, reply 5 clocks after TX end
      run(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, r8_ok, 48, 5,
          128'h1AA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      // no start bit at all
      run(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, '0, 48, 0,
          128'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      // corrupted arg, CRC checked, start bit on the first possible clock
      run(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, r8_flip, 48, 1,
          128'h1AB, 6'd8, 1'b0, 1'b1, 1'b0, 1'b0);
      // same corruption, R3-style no CRC check, start bit on the last allowed clock
      run(6'd8, 32'h1AA, 2'd2, 48'h48_0000_01AA_87, r8_flip, 48, RT,
          128'h1AB, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      // bad end bit
      run(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, r8_end0, 48, 3,
          128'h1AA, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      // CMD2 R136 with a stray start while busy
      run(6'd2, 32'h0, 2'd3, tx_cmd2, fr136, 136, 2,
          fr136[127:0], 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // abort during TX bit 20
      send(6'h11, 32'h1234_5678, 2'd1, acc_r);
      while (cyc < acc_r + 27) @(negedge clk);
      chk("abort_bit20_oe", 128'(cmd_oe), 128'd1);
      chk("abort_bit20_val", 128'(cmd_out), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cmd_oe", 128'(cmd_oe), 128'd0);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_done", 128'(done), 128'd0);
      rst = 1'b0;
      run(6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, '0, 48, 0,
          128'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_empty", 128'(q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
